tone_decoder: RTL and testbench

TONE_DECODER -- requirements
Module: tone_decoder

---
 rtl/tone_pkg.sv | 26 ++
 rtl/tone_decoder_classifier.sv | 32 +++
 rtl/tone_decoder.sv | 107 ++++++++++
 tb/tb_tone_decoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared constants and class encoding for the tone decoder: default note
// half-periods, period counter width and the NONE/C/D/E classification.
package tone_pkg;

   localparam int CNT_W       = 16;
   localparam int DEF_PITCH_C = 15289;
   localparam int DEF_PITCH_D = 13621;
   localparam int DEF_PITCH_E = 12135;

   typedef enum logic [1:0] {
      CLS_NONE = 2'd0,
      CLS_C    = 2'd1,
      CLS_D    = 2'd2,
      CLS_E    = 2'd3
   } tone_class_e;

   function automatic logic [2:0] class_onehot(input tone_class_e c);
      case (c)
         CLS_C:   return 3'b001;
         CLS_D:   return 3'b010;
         CLS_E:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/tone_decoder_classifier.sv
// Combinational period classifier: maps a measured full period onto the
// note whose window |P - 2*PITCH| <= TOL contains it, C before D before E.
module period_classifier
   import tone_pkg::*;
#(
   parameter int PITCH_C = DEF_PITCH_C,
   parameter int PITCH_D = DEF_PITCH_D,
   parameter int PITCH_E = DEF_PITCH_E,
   parameter int TOL     = 64
) (
   input  logic [CNT_W-1:0] period_i,
   output tone_class_e      cls_o
);

   function automatic logic in_window(input logic [CNT_W-1:0] p, input int half);
      int diff;
      diff = int'(p) - 2 * half;
      return (diff >= -TOL) && (diff <= TOL);
   endfunction

   always_comb begin
      cls_o = CLS_NONE;
      if (in_window(period_i, PITCH_C)) begin
         cls_o = CLS_C;
      end else if (in_window(period_i, PITCH_D)) begin
         cls_o = CLS_D;
      end else if (in_window(period_i, PITCH_E)) begin
         cls_o = CLS_E;
      end
   end

endmodule

// File: rtl/tone_decoder.sv
// Square-wave tone decoder: measures rising-edge to rising-edge periods,
// classifies them, and locks a note after CONFIRM consecutive matches.
module tone_decoder
   import tone_pkg::*;
#(
   parameter int PITCH_C = DEF_PITCH_C,
   parameter int PITCH_D = DEF_PITCH_D,
   parameter int PITCH_E = DEF_PITCH_E,
   parameter int TOL     = 64,
   parameter int CONFIRM = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       audio_in,
   output logic [2:0] note,
   output logic       note_strobe,
   output logic [5:0] ledc
);

   localparam int                CONF_W   = $clog2(CONFIRM + 1);
   localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONFIRM);
   localparam logic [CNT_W-1:0]  PER_MAX  = '1;

   logic              sync1_q, sync2_q, sync3_q;
   logic              rise_q, rise_d;
   logic [CNT_W-1:0]  per_q, per_d;
   logic              first_q, first_d;
   logic              present_q, present_d;
   tone_class_e       cand_q, cand_d;
   tone_class_e       cls, cls_eff;
   logic [CONF_W-1:0] cnt_q, cnt_d;
   logic [2:0]        note_q, note_d;
   logic              strobe_q, strobe_d;
   logic              timeout;

   period_classifier #(
      .PITCH_C (PITCH_C),
      .PITCH_D (PITCH_D),
      .PITCH_E (PITCH_E),
      .TOL     (TOL)
   ) u_classifier (
      .period_i (per_q),
      .cls_o    (cls)
   );

   always_comb begin
      rise_d    = sync2_q & ~sync3_q;
      timeout   = (per_q == PER_MAX);
      cls_eff   = first_q ? CLS_NONE : cls;
      per_d     = rise_q ? CNT_W'(1) : (timeout ? per_q : per_q + CNT_W'(1));
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      first_d   = first_q;
      present_d = present_q;
      // An edge in the same cycle as saturation still measures (and fails) a period.
      if (rise_q) begin
         first_d   = 1'b0;
         present_d = 1'b1;
         if ((cls_eff == cand_q) && (cls_eff != CLS_NONE)) begin
            if (cnt_q != CONF_MAX) cnt_d = cnt_q + CONF_W'(1);
         end else begin
            cand_d = cls_eff;
            cnt_d  = (cls_eff == CLS_NONE) ? '0 : CONF_W'(1);
         end
      end else if (timeout) begin
         cand_d    = CLS_NONE;
         cnt_d     = '0;
         first_d   = 1'b1;
         present_d = 1'b0;
      end
      note_d   = (cnt_q == CONF_MAX) ? class_onehot(cand_q) : 3'b000;
      strobe_d = (note_d != note_q);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         sync3_q   <= 1'b0;
         rise_q    <= 1'b0;
         per_q     <= '0;
         first_q   <= 1'b1;
         present_q <= 1'b0;
         cand_q    <= CLS_NONE;
         cnt_q     <= '0;
         note_q    <= 3'b000;
         strobe_q  <= 1'b0;
      end else begin
         sync1_q   <= audio_in;
         sync2_q   <= sync1_q;
         sync3_q   <= sync2_q;
         rise_q    <= rise_d;
         per_q     <= per_d;
         first_q   <= first_d;
         present_q <= present_d;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         note_q    <= note_d;
         strobe_q  <= strobe_d;
      end
   end

   assign note        = note_q;
   assign note_strobe = strobe_q;
   assign ledc        = {1'b0, present_q, (cnt_q != '0) && (cnt_q != CONF_MAX), note_q};

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: edge-list reference model feeds an expected-change
// queue; a negedge monitor compares every note change and strobe.
module tb_tone_decoder;

   localparam int P_C  = 60;
   localparam int P_D  = 58;
   localparam int P_E  = 40;
   localparam int TOLR = 3;
   localparam int CONF = 4;

   logic       clk = 1'b0;
   logic       resetn;
   logic       audio_in;
   logic [2:0] note;
   logic       note_strobe;
   logic [5:0] ledc;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   tone_decoder #(
      .PITCH_C (P_C),
      .PITCH_D (P_D),
      .PITCH_E (P_E),
      .TOL     (TOLR),
      .CONFIRM (CONF)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .audio_in    (audio_in),
      .note        (note),
      .note_strobe (note_strobe),
      .ledc        (ledc)
   );

   typedef struct {
      logic [2:0] val;
      int         t;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   req_seq = 0;
   int   ack_seq = 0;
   int   req_ledc4 = -1;
   logic [2:0] prev_note = 3'b000;

   // Reference model state, one update per rising edge of audio_in
   bit         m_have_prev;
   int         m_last;
   int         m_cand;
   int         m_cnt;
   logic [2:0] m_note;

   function automatic int absi(input int x);
      return (x < 0) ? -x : x;
   endfunction

   function automatic int classify(input int p);
      if (absi(p - 2 * P_C) <= TOLR) return 1;
      if (absi(p - 2 * P_D) <= TOLR) return 2;
      if (absi(p - 2 * P_E) <= TOLR) return 3;
      return 0;
   endfunction

   function automatic logic [2:0] onehot3(input int c);
      case (c)
         1:       return 3'b001;
         2:       return 3'b010;
         3:       return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   task automatic model_reset();
      m_have_prev = 1'b0;
      m_last      = 0;
      m_cand      = 0;
      m_cnt       = 0;
      m_note      = 3'b000;
   endtask

   // c = cycle on which audio_in was raised; the note reacts 5 cycles later,
   // a saturated counter drops it 65540 cycles after the previous rise.
   task automatic model_edge(input int c);
      int         cls;
      int         t;
      logic [2:0] nn;
      exp_t       e;
      t = c + 5;
      if (!m_have_prev) begin
         cls = 0;
      end else if (c - m_last >= 65535) begin
         cls = 0;
         t   = m_last + 65540;
      end else begin
         cls = classify(c - m_last);
      end
      if (cls != 0 && cls == m_cand) begin
         if (m_cnt < CONF) m_cnt++;
      end else begin
         m_cand = cls;
         m_cnt  = (cls == 0) ? 0 : 1;
      end
      nn = (m_cnt == CONF) ? onehot3(m_cand) : 3'b000;
      if (nn != m_note) begin
         e.val = nn;
         e.t   = t;
         exp_q.push_back(e);
      end
      m_note      = nn;
      m_have_prev = 1'b1;
      m_last      = c;
   endtask

   task automatic model_timeout();
      exp_t e;
      if (m_note != 3'b000) begin
         e.val = 3'b000;
         e.t   = m_last + 65540;
         exp_q.push_back(e);
      end
      model_reset();
   endtask

   task automatic send_period(input int period, input int high);
      audio_in = 1'b1;
      model_edge(cyc);
      repeat (high) @(posedge clk);
      #1 audio_in = 1'b0;
      repeat (period - high) @(posedge clk);
      #1;
   endtask

   task automatic check_point(input int ledc4);
      req_ledc4 = ledc4;
      req_seq++;
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      check_point(-1);
      resetn   = 1'b0;
      audio_in = 1'b0;
      model_reset();
      repeat (n) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (req_seq != ack_seq) begin
         ack_seq = req_seq;
         tests++;
         if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_changes: %0d expected note changes not seen, required 0 (cyc %0d)",
                     exp_q.size(), cyc);
         end
         if (req_ledc4 >= 0) begin
            tests++;
            if (ledc[4] !== req_ledc4[0]) begin
               fails++;
               $display("FAIL ledc4_present: got %b, required %0d (cyc %0d)", ledc[4], req_ledc4, cyc);
            end
         end
      end
      if (!resetn) begin
         tests++;
         if (note !== 3'b000 || note_strobe !== 1'b0 || ledc !== 6'd0) begin
            fails++;
            $display("FAIL reset_state: note=%b strobe=%b ledc=%b, required all zero (cyc %0d)",
                     note, note_strobe, ledc, cyc);
         end
         prev_note = 3'b000;
      end else begin
         if (note !== prev_note) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_change: note %b -> %b at cyc %0d, required no change",
                        prev_note, note, cyc);
            end else begin
               e = exp_q.pop_front();
               if (note !== e.val || cyc != e.t) begin
                  fails++;
                  $display("FAIL note_change: got %b at cyc %0d, required %b at cyc %0d",
                           note, cyc, e.val, e.t);
               end
            end
            tests++;
            if (note_strobe !== 1'b1 || ledc[2:0] !== note || ledc[5] !== 1'b0) begin
               fails++;
               $display("FAIL strobe_on_change: strobe=%b ledc=%b note=%b, required strobe=1 ledc[2:0]=note ledc[5]=0",
                        note_strobe, ledc, note);
            end
         end else begin
            tests++;
            if (note_strobe !== 1'b0) begin
               fails++;
               $display("FAIL spurious_strobe: strobe=%b with note steady %b, required 0 (cyc %0d)",
                        note_strobe, note, cyc);
            end
         end
         prev_note = note;
      end
   end

   initial begin
      repeat (120000) @(posedge clk);
      $display("FAIL watchdog: cycle %0d reached, required finish before 120000", cyc);
      $fatal(1, "bench did not finish in time");
   end

   initial begin
      int cls, len, half, jit, per;
      resetn   = 1'b0;
      audio_in = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk);
      #1;

      // Clean lock on C
      repeat (6) send_period(2 * P_C, P_C);
      check_point(1);

      // D lock, then switch to E
      do_reset(2);
      repeat (5) send_period(2 * P_D, P_D);
      repeat (5) send_period(2 * P_E, P_E);
      check_point(1);

      // Tolerance edge: +TOL matches, +TOL+1 does not
      do_reset(2);
      for (int i = 0; i < 8; i++) send_period((i % 2 == 0) ? 2 * P_C + TOLR : 2 * P_C + TOLR + 1, 50);
      check_point(1);

      // Duty cycle 10% and 90%
      do_reset(2);
      repeat (6) send_period(2 * P_C, 12);
      check_point(1);
      do_reset(2);
      repeat (6) send_period(2 * P_C, 108);
      check_point(1);

      // Random runs of notes with jitter slightly beyond tolerance
      do_reset(2);
      for (int r = 0; r < 12; r++) begin
         cls  = int'($urandom_range(1, 3));
         len  = int'($urandom_range(1, 7));
         half = (cls == 1) ? P_C : (cls == 2) ? P_D : P_E;
         for (int k = 0; k < len; k++) begin
            jit = int'($urandom_range(0, 2 * TOLR + 2)) - (TOLR + 1);
            per = 2 * half + jit;
            send_period(per, int'($urandom_range(3, per - 3)));
         end
      end
      check_point(1);

      // Lock on E, reset mid-period, relock
      do_reset(2);
      repeat (5) send_period(2 * P_E, P_E);
      check_point(1);
      audio_in = 1'b1;
      model_edge(cyc);
      repeat (20) @(posedge clk);
      #1 audio_in = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      do_reset(3);
      repeat (6) send_period(2 * P_E, 8);
      check_point(1);

      // Lock on C, then hold the input until the counter saturates
      repeat (6) send_period(2 * P_C, P_C);
      model_timeout();
      repeat (65560) @(posedge clk);
      #1;
      check_point(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
